bus_rsp_collect: RTL and testbench
==================================

Name: bus_rsp_collect

Overview:
- Return-path counterpart of the core's data-bus address decoder.
- Latches which slave a core load/store targets, waits for that slave's ready, then captures its read data.
- Returns a single-cycle response to the core with an error flag, so the core's memory stage gets one uniform handshake for every peripheral.
- Sits between the CPU data port and the ROM/GPIO/RAM/UART/CLINT/PIC slaves.

Parameters:
- NSLV, 7, number of slaves. Fixed slave ids: 0 rom, 1 key, 2 led, 3 ram, 4 uart, 5 clnt, 6 pic.
- TIMEOUT_CYC, 256, WAIT cycles allowed before a bus error (range 2..65535).

Ports:
- Clocking: one clock `clk`; asynchronous active-low reset `rst_n`.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request strobe (the d_en-equivalent)
- req_addr  in  32  byte address
- req_we  in  1  1 = store, 0 = load
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready
- slv_rdy  in  NSLV  per-slave ready/ack, bit i = slave id i
- slv_rdata  in  32*NSLV  per-slave read data; slave i occupies bits [32*i+31:32*i]
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  registered read data, valid with rsp_valid
- rsp_err  out  1  bus error, valid with rsp_valid
- busy  out  1  high in WAIT or RESP

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, sel=7, timeout counter=0.
- Reset is honoured at any time, including mid-transaction. The pending transaction is dropped and no response is issued.
- Address map, first match wins:
  - 0x1100_0000 → uart
  - 0x0000_0000–0x0FFF_FFFF → rom
  - ==0x1000_0000 → key
  - ==0x1000_0004 → led
  - 0x2000_0000–0x2FFF_FFFF → ram
  - 0x3000_0000–0x3FFF_FFFF → clnt
  - 0x4000_0000–0x4FFF_FFFF → pic
  - anything else → unmapped (id 7)
- States: IDLE, WAIT, RESP.
- IDLE, on accept at cycle T:
  - Register sel.
  - Mapped address: go to WAIT, counter cleared.
  - Unmapped address: go to RESP with rsp_err=1 and rsp_rdata=0. rsp_valid is high at T+1.
- WAIT:
  - Only slv_rdy[sel] is sampled; ready from any other slave is ignored.
  - If slv_rdy[sel]=1: capture rsp_rdata. The captured value is slv_rdata[sel] for a load and 0 for a store. Set rsp_err=0 and go to RESP.
  - Otherwise the counter increments.
  - Minimum latency: ready at T+1 gives rsp_valid at T+2.
  - Ready is not sampled in the accept cycle.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_rdata and rsp_err hold their values until the next capture.
  - req_valid in RESP is not accepted; the core must hold it until IDLE.
- req_addr and req_we are sampled only at accept; changes during WAIT have no effect.
- req_ready is a pure decode of state==IDLE, with no combinational path from req_valid.

Optional Feature:
- Macro: BUS_RSP_TIMEOUT_EN.
- Defined:
  - On the WAIT cycle where counter == TIMEOUT_CYC-1 and slv_rdy[sel]=0, go to RESP with rsp_err=1 and rsp_rdata=0.
  - If ready and the terminal count occur in the same cycle, ready wins.
  - Counter width is 16 bits.
- Undefined:
  - No counter logic is present.
  - WAIT holds indefinitely until ready arrives; a slave that never asserts ready hangs the core.

Decomposition:
- Shared package/header bus_pkg holds:
  - slave id constants SLV_ROM..SLV_PIC and SLV_NONE=7
  - region base/limit constants
  - state encodings
- Sub-module bus_slv_decode: combinational, req_addr → 3-bit slave id, implementing the address map above. It is reusable by the enable-generating decoder.

Test Plan:
- Load 0x2000_0010, ram ready at T+3 with rdata 0xA5A5_1234 → rsp_valid only at T+4, rsp_rdata=0xA5A5_1234, rsp_err=0, busy high T+1..T+4.
- Store 0x1000_0004, led ready at T+1 with rdata 0xFFFF_FFFF → rsp_valid at T+2, rsp_rdata=0, rsp_err=0.
- Load 0x1000_0008 (unmapped) → rsp_valid at T+1, rsp_err=1, rsp_rdata=0, no WAIT cycle.
- Load 0x1100_0000 while key and ram ready toggle every cycle and uart ready at T+5 → only uart ready completes; rsp_valid at T+6.
- With BUS_RSP_TIMEOUT_EN and TIMEOUT_CYC=4, load 0x4000_0000 with pic never ready → rsp_err=1 at T+5. Repeat with ready on the terminal cycle → rsp_err=0.
- rst_n low at T+2 during WAIT → outputs at reset values immediately, no rsp_valid; a new request after release completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus return path: slave ids, address regions and FSM states.
package bus_pkg;

    localparam logic [2:0] SLV_ROM  = 3'd0;
    localparam logic [2:0] SLV_KEY  = 3'd1;
    localparam logic [2:0] SLV_LED  = 3'd2;
    localparam logic [2:0] SLV_RAM  = 3'd3;
    localparam logic [2:0] SLV_UART = 3'd4;
    localparam logic [2:0] SLV_CLNT = 3'd5;
    localparam logic [2:0] SLV_PIC  = 3'd6;
    localparam logic [2:0] SLV_NONE = 3'd7;

    localparam logic [31:0] UART_ADDR  = 32'h1100_0000;
    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT  = 32'h0FFF_FFFF;
    localparam logic [31:0] KEY_ADDR   = 32'h1000_0000;
    localparam logic [31:0] LED_ADDR   = 32'h1000_0004;
    localparam logic [31:0] RAM_BASE   = 32'h2000_0000;
    localparam logic [31:0] RAM_LIMIT  = 32'h2FFF_FFFF;
    localparam logic [31:0] CLNT_BASE  = 32'h3000_0000;
    localparam logic [31:0] CLNT_LIMIT = 32'h3FFF_FFFF;
    localparam logic [31:0] PIC_BASE   = 32'h4000_0000;
    localparam logic [31:0] PIC_LIMIT  = 32'h4FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/bus_slv_decode.sv
// Combinational address-to-slave-id decode; first matching region wins, misses map to SLV_NONE.
module bus_slv_decode
    import bus_pkg::*;
(
    input  logic [31:0] addr,
    output logic [2:0]  sel
);

    // ordered priority decode; the UART address sits in front of the ROM range check
    always_comb begin
        sel = SLV_NONE;
        if (addr == UART_ADDR) begin
            sel = SLV_UART;
        end else if (in_region(addr, ROM_BASE, ROM_LIMIT)) begin
            sel = SLV_ROM;
        end else if (addr == KEY_ADDR) begin
            sel = SLV_KEY;
        end else if (addr == LED_ADDR) begin
            sel = SLV_LED;
        end else if (in_region(addr, RAM_BASE, RAM_LIMIT)) begin
            sel = SLV_RAM;
        end else if (in_region(addr, CLNT_BASE, CLNT_LIMIT)) begin
            sel = SLV_CLNT;
        end else if (in_region(addr, PIC_BASE, PIC_LIMIT)) begin
            sel = SLV_PIC;
        end else begin
            sel = SLV_NONE;
        end
    end

endmodule

// File: rtl/bus_rsp_collect.sv
// Collects the addressed slave's ready/read data and returns a one-cycle response to the core.
// Optional WAIT timeout (bus error) enabled by defining BUS_RSP_TIMEOUT_EN.
module bus_rsp_collect
    import bus_pkg::*;
#(
    parameter int NSLV        = 7,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    input  logic [31:0]          req_addr,
    input  logic                 req_we,
    output logic                 req_ready,
    input  logic [NSLV-1:0]      slv_rdy,
    input  logic [32*NSLV-1:0]   slv_rdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must lie in 2..65535");
    end

    state_e      state_r;
    state_e      state_nx_s;
    logic [2:0]  dec_sel_s;
    logic [2:0]  sel_r;
    logic        we_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        sel_rdy_s;
    logic [31:0] sel_data_s;
    logic        accept_s;
    logic        capture_s;
    logic        fault_s;

    bus_slv_decode u_decode (
        .addr (req_addr),
        .sel  (dec_sel_s)
    );

    // pick out the latched slave's ready and data; every other slave is ignored
    always_comb begin
        sel_rdy_s  = 1'b0;
        sel_data_s = 32'h0000_0000;
        for (int i = 0; i < NSLV; i++) begin
            sel_rdy_s  = (sel_r == 3'(i)) ? slv_rdy[i] : sel_rdy_s;
            sel_data_s = (sel_r == 3'(i)) ? slv_rdata[32*i +: 32] : sel_data_s;
        end
    end

`ifdef BUS_RSP_TIMEOUT_EN
    localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_r;

    // WAIT-cycle counter, cleared on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (accept_s) begin
            cnt_r <= 16'd0;
        end else if (state_r == ST_WAIT && !sel_rdy_s) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end
`endif

    // next-state decode; ready is only looked at from WAIT, never in the accept cycle
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        fault_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = (dec_sel_s == SLV_NONE) ? ST_RESP : ST_WAIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sel_rdy_s) begin
                    capture_s  = 1'b1;
                    state_nx_s = ST_RESP;
                end
`ifdef BUS_RSP_TIMEOUT_EN
                else if (cnt_r == TERM_CNT) begin
                    fault_s    = 1'b1;
                    state_nx_s = ST_RESP;
                end
`endif
                else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // state, latched request attributes and response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= SLV_NONE;
            we_r        <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                sel_r <= dec_sel_s;
                we_r  <= req_we;
                if (dec_sel_s == SLV_NONE) begin
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b1;
                end
            end else if (capture_s) begin
                rsp_rdata_r <= we_r ? 32'h0000_0000 : sel_data_s;
                rsp_err_r   <= 1'b0;
            end else if (fault_s) begin
                rsp_rdata_r <= 32'h0000_0000;
                rsp_err_r   <= 1'b1;
            end
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign busy      = (state_r == ST_WAIT) || (state_r == ST_RESP);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_bus_rsp_collect.sv
// Self-checking bench for bus_rsp_collect: transaction-level model compared every cycle plus directed literal checks.
module tb_bus_rsp_collect;

`ifdef BUS_RSP_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 256;
`endif
    localparam int NSLV = 7;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid;
    logic [31:0]          req_addr;
    logic                 req_we;
    logic                 req_ready;
    logic [NSLV-1:0]      slv_rdy;
    logic [32*NSLV-1:0]   slv_rdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    bus_rsp_collect #(.NSLV(NSLV), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_ready (req_ready),
        .slv_rdy   (slv_rdy),
        .slv_rdata (slv_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // address map from the slave list, first match wins; 7 means unmapped
    function automatic int map_addr(input logic [31:0] a);
        if (a == 32'h1100_0000) return 4;
        if (a[31:28] == 4'h0) return 0;
        if (a == 32'h1000_0000) return 1;
        if (a == 32'h1000_0004) return 2;
        if (a[31:28] == 4'h2) return 3;
        if (a[31:28] == 4'h3) return 5;
        if (a[31:28] == 4'h4) return 6;
        return 7;
    endfunction

    // transaction model: a pending target, how long it has waited, and the last response
    bit          m_pending = 1'b0;
    bit          m_resp    = 1'b0;
    int          m_tgt     = 0;
    bit          m_store   = 1'b0;
    int          m_waited  = 0;
    logic [31:0] m_rdata   = 32'h0;
    logic        m_err     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pending = 1'b0;
            m_resp    = 1'b0;
            m_rdata   = 32'h0;
            m_err     = 1'b0;
            m_waited  = 0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_pending) begin
            if (slv_rdy[m_tgt]) begin
                m_pending = 1'b0;
                m_resp    = 1'b1;
                m_rdata   = m_store ? 32'h0 : slv_rdata[32*m_tgt +: 32];
                m_err     = 1'b0;
            end else begin
                m_waited++;
`ifdef BUS_RSP_TIMEOUT_EN
                if (m_waited == TMO) begin
                    m_pending = 1'b0;
                    m_resp    = 1'b1;
                    m_rdata   = 32'h0;
                    m_err     = 1'b1;
                end
`endif
            end
        end else if (req_valid) begin
            m_tgt = map_addr(req_addr);
            if (m_tgt == 7) begin
                m_resp  = 1'b1;
                m_rdata = 32'h0;
                m_err   = 1'b1;
            end else begin
                m_pending = 1'b1;
                m_store   = req_we;
                m_waited  = 0;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("req_ready", {31'd0, req_ready}, {31'd0, !(m_pending || m_resp)});
        chk("busy",      {31'd0, busy},      {31'd0, (m_pending || m_resp)});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err",   {31'd0, rsp_err},   {31'd0, m_err});
    end

    // issue one request, then drive slave ready per cycle; lat = k of first rsp_valid (cycle T+k)
    task automatic run_txn(input logic [31:0] addr, input logic we, input int rdy_k,
                           input int rdy_id, input bit toggle, input int max_k,
                           output int lat, output logic [31:0] rd, output logic er);
        lat = 0;
        rd  = 32'hx;
        er  = 1'bx;
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_we    = ~we;
        for (int k = 1; k <= max_k; k++) begin
            slv_rdy = '0;
            if (toggle) begin
                slv_rdy[1] = k[0];
                slv_rdy[3] = k[0];
            end
            if (k == rdy_k) slv_rdy[rdy_id] = 1'b1;
            @(negedge clk);
            if (rsp_valid && lat == 0) begin
                lat = k;
                rd  = rsp_rdata;
                er  = rsp_err;
            end
            @(posedge clk);
            #1;
        end
        slv_rdy = '0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_we    = 1'b0;
        slv_rdy   = '0;
        for (int i = 0; i < NSLV; i++) slv_rdata[32*i +: 32] = 32'hD0D0_0000 + 32'(i);
        slv_rdata[32*3 +: 32] = 32'hA5A5_1234;
        slv_rdata[32*2 +: 32] = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_busy",  {31'd0, busy},      32'd0);
        chk("reset_rdata", rsp_rdata,          32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_txn(32'h2000_0010, 1'b0, 3, 3, 1'b0, 8, lat, rd, er);
        chk("ram_load_lat",   32'(lat), 32'd4);
        chk("ram_load_rdata", rd,       32'hA5A5_1234);
        chk("ram_load_err",   {31'd0, er}, 32'd0);

        run_txn(32'h1000_0004, 1'b1, 1, 2, 1'b0, 4, lat, rd, er);
        chk("led_store_lat",   32'(lat), 32'd2);
        chk("led_store_rdata", rd,       32'h0);
        chk("led_store_err",   {31'd0, er}, 32'd0);

        run_txn(32'h1000_0008, 1'b0, 0, 0, 1'b0, 4, lat, rd, er);
        chk("unmapped_lat",   32'(lat), 32'd1);
        chk("unmapped_rdata", rd,       32'h0);
        chk("unmapped_err",   {31'd0, er}, 32'd1);

        run_txn(32'h1100_0000, 1'b0, 5, 4, 1'b1, 9, lat, rd, er);
        chk("uart_lat",   32'(lat), 32'd6);
        chk("uart_rdata", rd,       32'hD0D0_0004);
        chk("uart_err",   {31'd0, er}, 32'd0);

        run_txn(32'h0000_0100, 1'b0, 2, 0, 1'b0, 5, lat, rd, er);
        chk("rom_lat",   32'(lat), 32'd3);
        chk("rom_rdata", rd,       32'hD0D0_0000);

`ifdef BUS_RSP_TIMEOUT_EN
        run_txn(32'h4000_0000, 1'b0, 0, 6, 1'b0, 8, lat, rd, er);
        chk("tmo_lat",   32'(lat), 32'd5);
        chk("tmo_rdata", rd,       32'h0);
        chk("tmo_err",   {31'd0, er}, 32'd1);
        run_txn(32'h4000_0000, 1'b0, 4, 6, 1'b0, 8, lat, rd, er);
        chk("tmo_edge_lat",   32'(lat), 32'd5);
        chk("tmo_edge_rdata", rd,       32'hD0D0_0006);
        chk("tmo_edge_err",   {31'd0, er}, 32'd0);
`else
        run_txn(32'h4000_0000, 1'b0, 10, 6, 1'b0, 14, lat, rd, er);
        chk("pic_slow_lat",   32'(lat), 32'd11);
        chk("pic_slow_rdata", rd,       32'hD0D0_0006);
        chk("pic_slow_err",   {31'd0, er}, 32'd0);
`endif

        // reset in the middle of a WAIT: response dropped, outputs back to reset values at once
        req_valid = 1'b1;
        req_addr  = 32'h2000_0000;
        req_we    = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_busy",  {31'd0, busy},      32'd0);
        chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rdata", rsp_rdata,          32'h0);
        chk("midrst_err",   {31'd0, rsp_err},   32'd0);
        slv_rdy[3] = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) lat++;
            @(posedge clk);
            #1;
        end
        slv_rdy = '0;
        chk("midrst_no_rsp", 32'(lat), 32'd0);

        run_txn(32'h2000_0020, 1'b0, 1, 3, 1'b0, 4, lat, rd, er);
        chk("post_rst_lat",   32'(lat), 32'd2);
        chk("post_rst_rdata", rd,       32'hA5A5_1234);
        chk("post_rst_err",   {31'd0, er}, 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, limit %0d ns", 100000);
        $fatal(1);
    end

endmodule
